// File: rtl/gzip_pkg.sv
// Shared definitions for the gzip member framer.
// Holds the RFC1952 header constants, the header/trailer sizes and the
// framer state encoding.
package gzip_pkg;

  localparam logic [7:0] GZ_ID1        = 8'h1F;
  localparam logic [7:0] GZ_ID2        = 8'h8B;
  localparam logic [7:0] GZ_CM_DEFLATE = 8'h08;
  localparam int         GZ_HDR_BYTES  = 10;
  localparam int         GZ_TRL_BYTES  = 8;

  typedef enum logic [3:0] {
    GZ_IDLE,
    GZ_HDR0,
    GZ_HDR1,
    GZ_HDR2,
    GZ_DATA,
    GZ_WAIT_T,
    GZ_TRL0,
    GZ_TRL1,
    GZ_FLUSH
  } gz_frame_state_t;

endpackage

// File: rtl/gzip_byte_packer.sv
// Eight-byte holding buffer with fill count.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   app_en          append app_cnt bytes of app_data (lanes [7:0] first)
//   app_data        bytes to append
//   app_cnt         bytes to append, 1..4 (0 or >4 means 4)
//   cons_en         drop cons_cnt bytes from the bottom of the buffer
//   cons_cnt        bytes consumed, 1..4
//   out_word        lower four bytes of the buffer
//   hcnt            current fill count 0..8
//   hcnt_nxt        fill count after this cycle's consume and append
// Consume is applied before append, so both may happen in one cycle.
// Bytes above hcnt are always zero, which lets an append be a plain OR.
module gzip_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        app_en,
  input  logic [31:0] app_data,
  input  logic [2:0]  app_cnt,
  input  logic        cons_en,
  input  logic [2:0]  cons_cnt,
  output logic [31:0] out_word,
  output logic [3:0]  hcnt,
  output logic [3:0]  hcnt_nxt
);

  logic [63:0] hold_q, hold_d, shifted, app_word;
  logic [3:0]  hcnt_q, hcnt_d, base, app_n;
  logic [31:0] app_mask;

  always_comb begin
    shifted = hold_q;
    base    = hcnt_q;
    if (cons_en) begin
      shifted = hold_q >> {cons_cnt, 3'b000};
      base    = hcnt_q - {1'b0, cons_cnt};
    end
    app_mask = 32'hFFFF_FFFF;
    app_n    = 4'd4;
    if (app_cnt != 3'd0 && app_cnt < 3'd4) begin
      app_mask = (32'h1 << {app_cnt, 3'b000}) - 32'h1;
      app_n    = {1'b0, app_cnt};
    end
    app_word = {32'h0, app_data & app_mask} << {base, 3'b000};
    hold_d   = shifted;
    hcnt_d   = base;
    if (app_en) begin
      hold_d = shifted | app_word;
      hcnt_d = base + app_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 64'h0;
      hcnt_q <= 4'd0;
    end else begin
      hold_q <= hold_d;
      hcnt_q <= hcnt_d;
    end
  end

  assign out_word = hold_q[31:0];
  assign hcnt     = hcnt_q;
  assign hcnt_nxt = hcnt_d;

endmodule

// File: rtl/gzip_member_framer.sv
// Wraps a raw Deflate word stream into one RFC1952 gzip member:
// 10-byte header, Deflate bytes, 8-byte trailer (CRC32, ISIZE).
// All words carry the first stream byte in bits [7:0].
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start                         begin a member (only honoured in IDLE)
//   s_valid/s_ready/s_data        Deflate input words
//   s_last/s_bytes                final word marker and its valid lane count
//   trailer_valid/crc32_in/isize_in  trailer values, held until member end
//   mtime_in                      header MTIME (only with GZIP_FRAME_MTIME_EN)
//   m_valid/m_ready/m_data        framed output words
//   m_last/m_bytes                final word marker and its valid lane count
//   busy                          member in progress
// Build option: GZIP_FRAME_MTIME_EN adds mtime_in, sampled on the accepted
// start; without it MTIME is zero.
//
// state  | meaning
// IDLE   | waiting for start
// HDR0   | append ID1 ID2 CM FLG
// HDR1   | append MTIME (needs room for 4 bytes)
// HDR2   | append XFL OS
// DATA   | accept Deflate words until s_last
// WAIT_T | wait for trailer_valid
// TRL0   | append CRC32
// TRL1   | append ISIZE
// FLUSH  | drain buffer, final word carries m_last
module gzip_member_framer
  import gzip_pkg::*;
#(
  parameter logic [7:0] OS_BYTE  = 8'hFF,
  parameter logic [7:0] XFL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [2:0]  s_bytes,
  input  logic        trailer_valid,
  input  logic [31:0] crc32_in,
  input  logic [31:0] isize_in,
`ifdef GZIP_FRAME_MTIME_EN
  input  logic [31:0] mtime_in,
`endif
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic [2:0]  m_bytes,
  output logic        busy
);

  gz_frame_state_t state_q, state_d;
  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic [2:0]  m_bytes_q, m_bytes_d;
  logic        busy_q, busy_d;
  logic [31:0] mtime_val;

  logic        app_en, cons_en;
  logic [31:0] app_data, out_word;
  logic [2:0]  app_cnt, cons_cnt, s_cnt;
  logic [3:0]  hcnt, hcnt_nxt;
  logic        s_fire, m_fire, out_free, load_full, load_last;

`ifdef GZIP_FRAME_MTIME_EN
  logic [31:0] mtime_q, mtime_d;
  assign mtime_val = mtime_q;
  always_comb begin
    mtime_d = mtime_q;
    if (state_q == GZ_IDLE && start) mtime_d = mtime_in;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtime_q <= 32'h0;
    else     mtime_q <= mtime_d;
  end
`else
  assign mtime_val = 32'h0;
`endif

  gzip_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .app_en   (app_en),
    .app_data (app_data),
    .app_cnt  (app_cnt),
    .cons_en  (cons_en),
    .cons_cnt (cons_cnt),
    .out_word (out_word),
    .hcnt     (hcnt),
    .hcnt_nxt (hcnt_nxt)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_bytes_d = m_bytes_q;
    app_en    = 1'b0;
    app_data  = 32'h0;
    app_cnt   = 3'd4;

    s_fire   = s_valid & s_ready_q;
    m_fire   = m_valid_q & m_ready;
    out_free = ~m_valid_q | m_ready;
    s_cnt    = (s_last && s_bytes != 3'd0 && s_bytes <= 3'd4) ? s_bytes : 3'd4;

    // Outside FLUSH only whole words leave the buffer; in FLUSH the
    // remaining 1..4 bytes form the final word.
    load_full = out_free && (hcnt > 4'd4 || (hcnt == 4'd4 && state_q != GZ_FLUSH));
    load_last = out_free && state_q == GZ_FLUSH && hcnt != 4'd0 && hcnt <= 4'd4;
    cons_en   = load_full | load_last;
    cons_cnt  = load_last ? hcnt[2:0] : 3'd4;

    if (cons_en) begin
      m_valid_d = 1'b1;
      m_data_d  = out_word;
      m_last_d  = load_last;
      m_bytes_d = cons_cnt;
    end else if (m_fire) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      m_bytes_d = 3'd4;
    end

    case (state_q)
      GZ_IDLE: begin
        if (start) begin
          state_d = GZ_HDR0;
          busy_d  = 1'b1;
        end
      end
      GZ_HDR0: begin
        app_en   = 1'b1;
        app_data = {8'h00, GZ_CM_DEFLATE, GZ_ID2, GZ_ID1};
        state_d  = GZ_HDR1;
      end
      GZ_HDR1: begin
        if (hcnt <= 4'd4) begin
          app_en   = 1'b1;
          app_data = mtime_val;
          state_d  = GZ_HDR2;
        end
      end
      GZ_HDR2: begin
        if (hcnt <= 4'd6) begin
          app_en   = 1'b1;
          app_data = {16'h0, OS_BYTE, XFL_BYTE};
          app_cnt  = 3'd2;
          state_d  = GZ_DATA;
        end
      end
      GZ_DATA: begin
        if (s_fire) begin
          app_en   = 1'b1;
          app_data = s_data;
          app_cnt  = s_cnt;
          if (s_last) state_d = GZ_WAIT_T;
        end
      end
      GZ_WAIT_T: begin
        if (trailer_valid) state_d = GZ_TRL0;
      end
      GZ_TRL0: begin
        if (hcnt <= 4'd4) begin
          app_en   = 1'b1;
          app_data = crc32_in;
          state_d  = GZ_TRL1;
        end
      end
      GZ_TRL1: begin
        if (hcnt <= 4'd4) begin
          app_en   = 1'b1;
          app_data = isize_in;
          state_d  = GZ_FLUSH;
        end
      end
      GZ_FLUSH: begin
        if (m_fire && m_last_q) begin
          state_d = GZ_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = GZ_IDLE;
    endcase

    // Registered ready: with hcnt<=4 next cycle, a full 4-byte append fits.
    s_ready_d = (state_d == GZ_DATA) && (hcnt_nxt <= 4'd4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GZ_IDLE;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 32'h0;
      m_last_q  <= 1'b0;
      m_bytes_q <= 3'd4;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_bytes_q <= m_bytes_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_bytes = m_bytes_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_gzip_member_framer.sv
module tb_gzip_member_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'h0;
  logic        s_last = 1'b0;
  logic [2:0]  s_bytes = 3'd4;
  logic        trailer_valid = 1'b0;
  logic [31:0] crc32_in = 32'h0;
  logic [31:0] isize_in = 32'h0;
`ifdef GZIP_FRAME_MTIME_EN
  logic [31:0] mtime_in = 32'h0;
`endif
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic [2:0]  m_bytes;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] data_q[$];

  always #5 clk = ~clk;

  gzip_member_framer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_bytes       (s_bytes),
    .trailer_valid (trailer_valid),
    .crc32_in      (crc32_in),
    .isize_in      (isize_in),
`ifdef GZIP_FRAME_MTIME_EN
    .mtime_in      (mtime_in),
`endif
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_bytes       (m_bytes),
    .busy          (busy)
  );

  // Input word idx built from data_q; lanes past the end get random junk.
  function automatic logic [31:0] in_word(input int idx);
    logic [31:0] w;
    w = $urandom;
    for (int b = 0; b < 4; b++)
      if (idx * 4 + b < data_q.size()) w[b*8 +: 8] = data_q[idx*4 + b];
    return w;
  endfunction

  task automatic fill_random(input int n);
    data_q = {};
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Runs one member: the expected byte stream is header + data_q + trailer,
  // cut into 4-byte words. trl_delay<0 raises trailer_valid from the start.
  task automatic run_member(input string name, input logic [31:0] crc,
                            input logic [31:0] isize, input logic [31:0] mt,
                            input int ready_pct, input int trl_delay,
                            input bit inject);
    logic [7:0]  exp_b[$];
    logic [31:0] mt_exp, ew, mask, prev_data;
    logic        prev_last, prev_stall;
    logic [2:0]  prev_bytes, eb;
    int nb, nw_in, nw_out, widx, k, cyc, since_last, rem;
    bit done;

`ifdef GZIP_FRAME_MTIME_EN
    mtime_in = mt;
    mt_exp = mt;
`else
    mt_exp = 32'h0;
`endif
    exp_b = '{8'h1F, 8'h8B, 8'h08, 8'h00};
    for (int b = 0; b < 4; b++) exp_b.push_back(mt_exp[b*8 +: 8]);
    exp_b.push_back(8'h00);
    exp_b.push_back(8'hFF);
    foreach (data_q[i]) exp_b.push_back(data_q[i]);
    for (int b = 0; b < 4; b++) exp_b.push_back(crc[b*8 +: 8]);
    for (int b = 0; b < 4; b++) exp_b.push_back(isize[b*8 +: 8]);

    nb     = data_q.size();
    nw_in  = (nb + 3) / 4;
    nw_out = (exp_b.size() + 3) / 4;

    crc32_in      = crc;
    isize_in      = isize;
    trailer_valid = (trl_delay < 0);
    m_ready       = 1'b0;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;

    widx = 0; k = 0; cyc = 0; since_last = 0; done = 0; prev_stall = 0;
    prev_data = 0; prev_last = 0; prev_bytes = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last || m_bytes !== prev_bytes) begin
          n_err++;
          $display("FAIL %s stall_hold: got v=%0b d=%h l=%0b b=%0d, required v=1 d=%h l=%0b b=%0d",
                   name, m_valid, m_data, m_last, m_bytes, prev_data, prev_last, prev_bytes);
        end
      end
      if (inject) start = (cyc == 15);
      if (widx < nw_in) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = in_word(widx);
        s_last  = (widx == nw_in - 1);
        if (widx == nw_in - 1) begin
          rem = nb - 4 * (nw_in - 1);
          s_bytes = (rem == 4) ? (($urandom_range(0, 1) != 0) ? 3'd0 : 3'd4) : 3'(rem);
        end else begin
          s_bytes = 3'($urandom_range(0, 7));
        end
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        since_last++;
        if (trl_delay >= 0 && since_last > trl_delay) trailer_valid = 1'b1;
      end
      if (!trailer_valid && m_valid) begin
        n_cmp++;
        if (m_last !== 1'b0) begin
          n_err++;
          $display("FAIL %s early_last: m_last=%0b before trailer_valid, required 0", name, m_last);
        end
      end
      m_ready = ($urandom_range(0, 99) < ready_pct);
      if (s_valid && s_ready) widx++;
      if (m_valid && m_ready) begin
        ew = 32'h0; mask = 32'h0;
        rem = exp_b.size() - 4 * k;
        eb = (rem >= 4) ? 3'd4 : 3'(rem);
        for (int b = 0; b < 4; b++)
          if (b < rem) begin
            ew[b*8 +: 8]   = exp_b[4*k + b];
            mask[b*8 +: 8] = 8'hFF;
          end
        n_cmp++;
        if ((m_data & mask) !== ew || m_last !== (k == nw_out - 1) || m_bytes !== eb) begin
          n_err++;
          $display("FAIL %s word%0d: got d=%h l=%0b b=%0d, required d=%h (mask %h) l=%0b b=%0d",
                   name, k, m_data, m_last, m_bytes, ew, mask, (k == nw_out - 1), eb);
        end
        if (k == nw_out - 1 || m_last === 1'b1) done = 1;
        k++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_bytes = m_bytes;
    end
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: got %0d words, required %0d", name, k, nw_out);
    end
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || k !== nw_out) begin
      n_err++;
      $display("FAIL %s end_state: busy=%0b m_valid=%0b words=%0d, required 0/0/%0d",
               name, busy, m_valid, k, nw_out);
    end
    trailer_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (s_ready !== 0 || m_valid !== 0 || m_data !== 32'h0 || m_last !== 0 || m_bytes !== 3'd4 || busy !== 0) begin
      n_err++;
      $display("FAIL reset_values: got sr=%0b v=%0b d=%h l=%0b b=%0d busy=%0b, required 0 0 0 0 4 0",
               s_ready, m_valid, m_data, m_last, m_bytes, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 0 || m_valid !== 0 || busy !== 0) begin
      n_err++;
      $display("FAIL reset_release: got sr=%0b v=%0b busy=%0b, required 0 0 0", s_ready, m_valid, busy);
    end
  endtask

  task automatic test_single_word();
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_member("single_word", 32'hAABBCCDD, 32'h10, 32'h0, 100, 0, 0);
  endtask

  task automatic test_two_bytes();
    fill_random(2);
    run_member("two_bytes", $urandom, 32'd2, $urandom, 100, 0, 0);
  endtask

  task automatic test_random_stream();
    fill_random(1000);
    run_member("random_1000", $urandom, 32'd1000, $urandom, 55, -1, 0);
  endtask

  task automatic test_trailer_wait();
    fill_random(37);
    run_member("trailer_wait", $urandom, $urandom, $urandom, 80, 50, 0);
  endtask

  task automatic test_ignored();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = $urandom; s_last = 1'b1; m_ready = 1'b1;
      n_cmp++;
      if (s_ready !== 0 || m_valid !== 0 || busy !== 0) begin
        n_err++;
        $display("FAIL idle_svalid: got sr=%0b v=%0b busy=%0b, required 0 0 0", s_ready, m_valid, busy);
      end
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    fill_random(200);
    run_member("start_while_busy", $urandom, 32'd200, $urandom, 70, 3, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m_ready = 1'b1;
      n_cmp++;
      if (m_valid !== 0 || busy !== 0) begin
        n_err++;
        $display("FAIL extra_member: got v=%0b busy=%0b, required 0 0", m_valid, busy);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int widx;
    fill_random(64);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    widx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = in_word(widx); s_last = 1'b0;
      m_ready = ($urandom_range(0, 1) != 0);
      if (s_ready) widx++;
    end
    rst = 1'b1;
    s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 0 || busy !== 0 || s_ready !== 0 || m_last !== 0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%0b busy=%0b sr=%0b l=%0b, required 0 0 0 0", m_valid, busy, s_ready, m_last);
    end
    rst = 1'b0;
    @(negedge clk);
    fill_random(13);
    run_member("after_reset", $urandom, 32'd13, 32'h5F5E1000, 90, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int m = 0; m < 8; m++) begin
      fill_random($urandom_range(1, 9));
      run_member($sformatf("b2b_%0d", m), $urandom, $urandom, $urandom, 50, $urandom_range(0, 4), 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_bytes();
    test_random_stream();
    test_trailer_wait();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
